// File: rtl/ctrl_pipe_if.sv
// ctrl_pipe_if: handshake bundle between the decoder/hazard unit (master)
// and the control-bundle pipeline (slave). Widths must match the
// CTRL_W / ALUOP_W parameters of the ctrl_pipe instance it connects to.
interface ctrl_pipe_if #(
    parameter int CTRL_W  = 14,
    parameter int ALUOP_W = 8
);
    // Decode-stage inputs
    logic [CTRL_W-1:0]  ctrlD;
    logic [ALUOP_W-1:0] alucontrolD;
    logic               divD;
    logic               validD;

    // Per-stage hold / clear from the hazard unit
    logic stallE, stallM, stallW;
    logic flushE, flushM, flushW;

    // Stage outputs
    logic [CTRL_W-1:0]  ctrlE, ctrlM, ctrlW;
    logic [ALUOP_W-1:0] alucontrolE;
    logic               validE, validM, validW;
    logic               divE;

    // Divide sequencer status
    logic               div_stall;
    logic               div_done;
    logic [31:0]        div_stall_cnt;

    modport master (
        output ctrlD, alucontrolD, divD, validD,
        output stallE, stallM, stallW, flushE, flushM, flushW,
        input  ctrlE, ctrlM, ctrlW, alucontrolE,
        input  validE, validM, validW, divE,
        input  div_stall, div_done, div_stall_cnt
    );

    modport slave (
        input  ctrlD, alucontrolD, divD, validD,
        input  stallE, stallM, stallW, flushE, flushM, flushW,
        output ctrlE, ctrlM, ctrlW, alucontrolE,
        output validE, validM, validW, divE,
        output div_stall, div_done, div_stall_cnt
    );
endinterface

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: carries the decoded control word and ALU code from Decode
// through the Execute, Memory and Writeback stage registers, and sequences
// multi-cycle DIV/DIVU in Execute by raising div_stall for DIV_CYCLES cycles.
// Optional build macro CTRL_PIPE_PERF_EN enables the saturating
// div_stall_cnt performance counter; without it the port reads zero.
module ctrl_pipe #(
    parameter int CTRL_W     = 14,
    parameter int ALUOP_W    = 8,
    parameter int DIV_CYCLES = 32
) (
    input logic        clk,
    input logic        rst,
    ctrl_pipe_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } divState_e;

    // The detect cycle accounts for one stall cycle, so BUSY counts down from DIV_CYCLES-2 to 0.
    localparam logic [7:0] CNT_LOAD = 8'(DIV_CYCLES - 2);

    logic [CTRL_W-1:0]  eCtrl, mCtrl, wCtrl;
    logic [ALUOP_W-1:0] eAlu;
    logic               eValid, mValid, wValid;
    logic               eDiv;

    divState_e          state, nextState;
    logic [7:0]         cnt, cntNext;
    logic               divStall;
    logic               divDone;
    logic               divStart;

    // Execute stage register: flush clears, stall holds, otherwise load from Decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eCtrl  <= '0;
            eAlu   <= '0;
            eValid <= 1'b0;
            eDiv   <= 1'b0;
        end else if (bus.flushE) begin
            eCtrl  <= '0;
            eAlu   <= '0;
            eValid <= 1'b0;
            eDiv   <= 1'b0;
        end else if (!bus.stallE) begin
            eCtrl  <= bus.ctrlD;
            eAlu   <= bus.alucontrolD;
            eValid <= bus.validD;
            eDiv   <= bus.divD;
        end
    end

    // Memory stage register: flush clears, stall holds, otherwise load from Execute.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mCtrl  <= '0;
            mValid <= 1'b0;
        end else if (bus.flushM) begin
            mCtrl  <= '0;
            mValid <= 1'b0;
        end else if (!bus.stallM) begin
            mCtrl  <= eCtrl;
            mValid <= eValid;
        end
    end

    // Writeback stage register: flush clears, stall holds, otherwise load from Memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wCtrl  <= '0;
            wValid <= 1'b0;
        end else if (bus.flushW) begin
            wCtrl  <= '0;
            wValid <= 1'b0;
        end else if (!bus.stallW) begin
            wCtrl  <= mCtrl;
            wValid <= mValid;
        end
    end

    // A flushed divide in Execute must not start the sequencer.
    assign divStart = eValid & eDiv & ~bus.flushE;

    // Divide sequencer state and down-counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= nextState;
            cnt   <= cntNext;
        end
    end

    // Divide sequencer next state and stall/done outputs.
    always_comb begin
        nextState = state;
        cntNext   = cnt;
        divStall  = 1'b0;
        divDone   = 1'b0;
        unique case (state)
            IDLE: begin
                if (divStart) begin
                    divStall  = 1'b1;
                    nextState = BUSY;
                    cntNext   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (bus.flushE) begin
                    // Abort: the divide left Execute, release the pipeline now.
                    nextState = IDLE;
                end else begin
                    divStall = 1'b1;
                    if (cnt == 8'd0) begin
                        nextState = DONE;
                    end else begin
                        cntNext = cnt - 8'd1;
                    end
                end
            end
            DONE: begin
                divDone = 1'b1;
                // Stay here while Execute is held so the same divide is not restarted.
                if (bus.flushE || !bus.stallE) begin
                    nextState = IDLE;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

`ifdef CTRL_PIPE_PERF_EN
    logic [31:0] perfCnt;

    function automatic logic [31:0] satInc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Count every edge on which the pipeline is held by a divide, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perfCnt <= '0;
        end else if (divStall) begin
            perfCnt <= satInc(perfCnt);
        end
    end

    assign bus.div_stall_cnt = perfCnt;
`else
    assign bus.div_stall_cnt = 32'h0;
`endif

    assign bus.ctrlE       = eCtrl;
    assign bus.ctrlM       = mCtrl;
    assign bus.ctrlW       = wCtrl;
    assign bus.alucontrolE = eAlu;
    assign bus.validE      = eValid;
    assign bus.validM      = mValid;
    assign bus.validW      = wValid;
    assign bus.divE        = eDiv;
    assign bus.div_stall   = divStall;
    assign bus.div_done    = divDone;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed bench for ctrl_pipe at DIV_CYCLES=32. Stage
// register behaviour is driven from a vector table; divide sequencing
// (full divide, abort, DONE hold, async reset, back-to-back with the
// performance counter) uses hand-written sequences.
module tb_ctrl_pipe;

    logic clk;
    logic rst;
    logic loopStall;
    logic manStall;
    int   nChecks;
    int   nFail;

`ifdef CTRL_PIPE_PERF_EN
    localparam logic [31:0] PERF_EXP = 32'd64;
`else
    localparam logic [31:0] PERF_EXP = 32'd0;
`endif

    ctrl_pipe_if #(.CTRL_W(14), .ALUOP_W(8)) bus ();

    ctrl_pipe #(.CTRL_W(14), .ALUOP_W(8), .DIV_CYCLES(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Hazard-unit model: optionally feed the divide stall back into Execute.
    assign bus.stallE = loopStall ? (bus.div_stall | manStall) : manStall;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] ctrlD;
        logic [7:0]  aluD;
        logic        validD;
        logic        stE, flE, stM, flM, stW, flW;
        logic [13:0] eCtrl;
        logic [7:0]  eAlu;
        logic        eVal;
        logic [13:0] mCtrl;
        logic        mVal;
        logic [13:0] wCtrl;
        logic        wVal;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic setD(input logic [13:0] c, input logic [7:0] a, input logic v, input logic d);
        bus.ctrlD       = c;
        bus.alucontrolD = a;
        bus.validD      = v;
        bus.divD        = d;
    endtask

    // Called at the negedge where the detect cycle is visible; returns the stall run length.
    task automatic waitStall(output int n);
        n = 0;
        while (bus.div_stall === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;
        nChecks   = 0;
        nFail     = 0;
        loopStall = 1'b0;
        manStall  = 1'b0;
        bus.flushE = 1'b0; bus.stallM = 1'b0; bus.flushM = 1'b0;
        bus.stallW = 1'b0; bus.flushW = 1'b0;
        setD(14'h3FFF, 8'h01, 1'b1, 1'b0);
        rst = 1'b1;

        //                ctrlD    alu    v     sE    fE    sM    fM    sW    fW    eCtrl    eAlu   eV    mCtrl    mV    wCtrl    wV
        vecs[0]  = '{14'h3FFF, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 14'h3FFF, 8'h01, 1'b1, 14'h0000, 1'b0, 14'h0000, 1'b0};
        vecs[1]  = '{14'h0001, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0001, 8'h02, 1'b1, 14'h3FFF, 1'b1, 14'h0000, 1'b0};
        vecs[2]  = '{14'h0002, 8'h03, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0002, 8'h03, 1'b1, 14'h0001, 1'b1, 14'h3FFF, 1'b1};
        vecs[3]  = '{14'h002A, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 14'h002A, 8'h04, 1'b1, 14'h0002, 1'b1, 14'h0001, 1'b1};
        vecs[4]  = '{14'h0003, 8'h05, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 8'h00, 1'b0, 14'h002A, 1'b1, 14'h0002, 1'b1};
        vecs[5]  = '{14'h002A, 8'h06, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 14'h002A, 8'h06, 1'b1, 14'h0000, 1'b0, 14'h002A, 1'b1};
        vecs[6]  = '{14'h0005, 8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 14'h002A, 8'h06, 1'b1, 14'h002A, 1'b1, 14'h0000, 1'b0};
        vecs[7]  = '{14'h0006, 8'h08, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 14'h002A, 8'h06, 1'b1, 14'h002A, 1'b1, 14'h002A, 1'b1};
        vecs[8]  = '{14'h0006, 8'h09, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 14'h002A, 8'h06, 1'b1, 14'h002A, 1'b1, 14'h002A, 1'b1};
        vecs[9]  = '{14'h0006, 8'h0A, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 14'h002A, 8'h06, 1'b1, 14'h002A, 1'b1, 14'h002A, 1'b1};
        vecs[10] = '{14'h0006, 8'h0B, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 14'h002A, 8'h06, 1'b1, 14'h002A, 1'b1, 14'h002A, 1'b1};
        vecs[11] = '{14'h0007, 8'h0C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 14'h0007, 8'h0C, 1'b0, 14'h002A, 1'b1, 14'h002A, 1'b1};
        vecs[12] = '{14'h0008, 8'h0D, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 14'h0008, 8'h0D, 1'b1, 14'h0000, 1'b0, 14'h002A, 1'b1};
        vecs[13] = '{14'h0009, 8'h0E, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 14'h0009, 8'h0E, 1'b1, 14'h0008, 1'b1, 14'h002A, 1'b1};
        vecs[14] = '{14'h000A, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 14'h000A, 8'h0F, 1'b1, 14'h0009, 1'b1, 14'h0000, 1'b0};
        vecs[15] = '{14'h0000, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0000, 8'h10, 1'b0, 14'h000A, 1'b1, 14'h0009, 1'b1};

        // Reset held across edges with a live Decode word
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst ctrlE", 32'(bus.ctrlE), 32'h0);
        chk("rst ctrlM", 32'(bus.ctrlM), 32'h0);
        chk("rst ctrlW", 32'(bus.ctrlW), 32'h0);
        chk("rst aluE", 32'(bus.alucontrolE), 32'h0);
        chk("rst valids", 32'({bus.validE, bus.validM, bus.validW, bus.divE}), 32'h0);
        chk("rst div_stall/done", 32'({bus.div_stall, bus.div_done}), 32'h0);
        chk("rst div_stall_cnt", bus.div_stall_cnt, 32'h0);
        rst = 1'b0;

        // Stage register vectors
        for (int i = 0; i < 16; i++) begin
            setD(vecs[i].ctrlD, vecs[i].aluD, vecs[i].validD, 1'b0);
            manStall   = vecs[i].stE;
            bus.flushE = vecs[i].flE;
            bus.stallM = vecs[i].stM;
            bus.flushM = vecs[i].flM;
            bus.stallW = vecs[i].stW;
            bus.flushW = vecs[i].flW;
            @(negedge clk);
            chk($sformatf("vec%0d ctrlE", i), 32'(bus.ctrlE), 32'(vecs[i].eCtrl));
            chk($sformatf("vec%0d aluE", i), 32'(bus.alucontrolE), 32'(vecs[i].eAlu));
            chk($sformatf("vec%0d validE", i), 32'(bus.validE), 32'(vecs[i].eVal));
            chk($sformatf("vec%0d ctrlM", i), 32'(bus.ctrlM), 32'(vecs[i].mCtrl));
            chk($sformatf("vec%0d validM", i), 32'(bus.validM), 32'(vecs[i].mVal));
            chk($sformatf("vec%0d ctrlW", i), 32'(bus.ctrlW), 32'(vecs[i].wCtrl));
            chk($sformatf("vec%0d validW", i), 32'(bus.validW), 32'(vecs[i].wVal));
            chk($sformatf("vec%0d div_stall", i), 32'(bus.div_stall), 32'h0);
        end
        manStall = 1'b0; bus.flushE = 1'b0; bus.stallM = 1'b0; bus.flushM = 1'b0;
        bus.stallW = 1'b0; bus.flushW = 1'b0;

        // Full divide with div_stall looped into stallE
        loopStall = 1'b1;
        setD(14'h0111, 8'h1A, 1'b1, 1'b1);
        @(negedge clk);
        setD(14'h0222, 8'h1B, 1'b1, 1'b0);
        waitStall(n);
        chk("div stall length", 32'(n), 32'd32);
        chk("div done", 32'({bus.div_done, bus.div_stall}), 32'b10);
        chk("div held in E", 32'({bus.divE, bus.ctrlE}), 32'({1'b1, 14'h0111}));
        @(negedge clk);
        chk("div done clears", 32'({bus.div_done, bus.div_stall}), 32'b00);
        chk("div next in E", 32'({bus.divE, bus.ctrlE}), 32'({1'b0, 14'h0222}));
        chk("div in M", 32'({bus.validM, bus.ctrlM}), 32'({1'b1, 14'h0111}));

        // Abort with flushE at BUSY cycle 10
        setD(14'h0333, 8'h1C, 1'b1, 1'b1);
        @(negedge clk);
        setD(14'h0000, 8'h00, 1'b0, 1'b0);
        chk("abort detect", 32'(bus.div_stall), 32'h1);
        for (int b = 0; b < 10; b++) @(negedge clk);
        chk("abort busy10 stall", 32'(bus.div_stall), 32'h1);
        bus.flushE = 1'b1;
        #1;
        chk("abort stall drops", 32'(bus.div_stall), 32'h0);
        @(negedge clk);
        bus.flushE = 1'b0;
        chk("abort E flushed", 32'(bus.validE), 32'h0);
        chk("abort idle", 32'({bus.div_done, bus.div_stall}), 32'b00);
        bad = 0;
        for (int b = 0; b < 6; b++) begin
            @(negedge clk);
            if (bus.div_done !== 1'b0 || bus.div_stall !== 1'b0) bad++;
        end
        chk("abort no done pulse", 32'(bad), 32'h0);

        // DONE held by an extra stallE for 4 cycles
        setD(14'h0444, 8'h1D, 1'b1, 1'b1);
        @(negedge clk);
        setD(14'h0555, 8'h1E, 1'b1, 1'b0);
        manStall = 1'b1;
        waitStall(n);
        chk("hold stall length", 32'(n), 32'd32);
        for (int k = 1; k <= 5; k++) begin
            chk($sformatf("hold done cyc%0d", k), 32'({bus.div_done, bus.div_stall}), 32'b10);
            if (k == 5) manStall = 1'b0;
            @(negedge clk);
        end
        chk("hold released", 32'({bus.div_done, bus.div_stall}), 32'b00);
        chk("hold next in E", 32'({bus.divE, bus.ctrlE}), 32'({1'b0, 14'h0555}));

        // Asynchronous reset in the middle of a divide
        setD(14'h0666, 8'h1F, 1'b1, 1'b1);
        @(negedge clk);
        setD(14'h0000, 8'h00, 1'b0, 1'b0);
        chk("midrst detect", 32'(bus.div_stall), 32'h1);
        for (int b = 0; b < 3; b++) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst stall drops", 32'(bus.div_stall), 32'h0);
        chk("midrst E cleared", 32'({bus.validE, bus.divE}), 32'h0);
        chk("midrst cnt cleared", bus.div_stall_cnt, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back divides and the performance counter
        setD(14'h0777, 8'h21, 1'b1, 1'b1);
        @(negedge clk);
        setD(14'h0888, 8'h22, 1'b1, 1'b1);
        waitStall(n);
        chk("b2b first length", 32'(n), 32'd32);
        chk("b2b first done", 32'(bus.div_done), 32'h1);
        @(negedge clk);
        setD(14'h0000, 8'h00, 1'b0, 1'b0);
        chk("b2b second in E", 32'({bus.divE, bus.ctrlE}), 32'({1'b1, 14'h0888}));
        waitStall(n);
        chk("b2b second length", 32'(n), 32'd32);
        chk("b2b second done", 32'(bus.div_done), 32'h1);
        chk("perf div_stall_cnt", bus.div_stall_cnt, PERF_EXP);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Parametrised control-bundle pipeline that sits directly after the instruction decoder of the MIPS core.
- Carries the decoded datapath control word and ALU opcode from Decode through Execute, Memory and Writeback stage registers, each with its own stall and flush.
- Contains a multi-cycle divide sequencer. It raises a pipeline stall request while a DIV/DIVU occupies Execute and reports completion to the hazard unit.

Parameters:
- CTRL_W, 14, width of the datapath control word (regwrite..hilo_write bundle).
- ALUOP_W, 8, width of the ALU control code.
- DIV_CYCLES, 32, total cycles div_stall is asserted per divide; legal range 2..255.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ctrlD  in  CTRL_W  decoded control word, Decode stage
- alucontrolD  in  ALUOP_W  decoded ALU code, Decode stage
- divD  in  1  Decode instruction is DIV or DIVU
- validD  in  1  Decode slot holds a real instruction (0 = bubble)
- stallE, stallM, stallW  in  1 each  hold the corresponding stage register
- flushE, flushM, flushW  in  1 each  clear the corresponding stage register
- ctrlE, ctrlM, ctrlW  out  CTRL_W each  stage control words
- alucontrolE  out  ALUOP_W  Execute ALU code
- validE, validM, validW  out  1 each  stage holds a real instruction
- divE  out  1  Execute instruction is a divide
- div_stall  out  1  stall request to the hazard unit
- div_done  out  1  divide result ready in Execute
- div_stall_cnt  out  32  performance counter (see Optional Feature)

Behaviour:
- Reset (async, rst=1): all stage registers zero, all valid flags 0, divE=0, FSM=IDLE, counter=0, div_stall=0, div_done=0, div_stall_cnt=0.
- Stage register update, evaluated per rising edge for each of E, M and W independently:
  - flushX=1: register cleared to zero and validX=0. Flush has priority over stall.
  - else stallX=1: register holds its value.
  - else: register loads the previous stage (E<-D, M<-E, W<-M), including the valid flag.
- Latency is 1 cycle per stage; ctrlW equals ctrlD from three unstalled cycles earlier.
- Stall and flush are not interlocked between stages. The hazard unit is responsible for consistency; e.g. stallE=1 with stallM=0 produces a duplicate in M, and this block does not prevent it.
- Divide FSM states: IDLE, BUSY, DONE. Counter cnt is 8 bits.
  - IDLE:
    - validE & divE & ~flushE: div_stall=1 combinationally in this same cycle; next state BUSY; cnt<=DIV_CYCLES-2.
    - otherwise div_stall=0.
  - BUSY:
    - div_stall=1; cnt decrements each cycle.
    - When cnt==0, next state DONE.
    - flushE=1 in any BUSY cycle: next state IDLE immediately (abort), and div_stall drops in that cycle.
  - DONE:
    - div_stall=0, div_done=1.
    - Remains in DONE while stallE=1 & flushE=0, so a held divide is never restarted.
    - Goes to IDLE on the edge where E reloads (stallE=0) or is flushed.
- A divide therefore asserts div_stall for exactly DIV_CYCLES consecutive cycles: 1 detect cycle, then DIV_CYCLES-1 BUSY cycles.
- Back-to-back divides: DONE->IDLE, and the next divide entering E is detected the following cycle. There is no gap cycle requirement.
- Reset asserted mid-divide returns to IDLE asynchronously; div_stall drops immediately.
- div_stall is combinational from the FSM state and the E-stage registers only. There is no path from the stall/flush inputs to div_stall except the flushE abort and suppression terms above.

Optional Feature:
- Macro: CTRL_PIPE_PERF_EN.
- Defined:
  - div_stall_cnt increments by 1 on every rising edge where div_stall=1.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared only by rst.
- Not defined: div_stall_cnt is tied to 32'h0 and no counter logic is synthesised. The port list is identical in both builds.

Test Plan:
- Reset: drive ctrlD=14'h3FFF, validD=1, hold rst=1 across edges -> all outputs 0. Release -> ctrlE=14'h3FFF one edge later, ctrlW three edges later.
- Stall/flush priority: load ctrlE=14'h2A; assert stallE=1 and flushE=1 together -> ctrlE=0, validE=0. stallE alone -> ctrlE held at 14'h2A over 5 cycles.
- Divide, DIV_CYCLES=32: validD=1, divD=1, hazard unit loops div_stall into stallE/stallD -> div_stall high for exactly 32 cycles, div_done=1 on cycle 33, divide reaches M the edge after.
- Abort: start a divide, assert flushE for one cycle at BUSY cycle 10 -> div_stall=0 in that cycle, FSM IDLE, no div_done pulse.
- DONE hold: divide completes while stallE=1 for 4 extra cycles -> div_done stays 1 for 5 cycles, div_stall stays 0, no restart.
- Perf counter: with CTRL_PIPE_PERF_EN, two divides at DIV_CYCLES=8 -> div_stall_cnt=16. Without the macro -> div_stall_cnt=0.
